priority_request_arbiter_8: RTL

// - Shares one downstream resource (bus/datapath port) among 8 requesters.
// - Priority is high-first: requester 7 is highest and requester 0 is lowest.
// - Issues a registered one-hot grant plus an encoded index, holds it for the winner,

---
 rtl/priority_request_arbiter_8.sv | 123 ++++++++++++
 1 files changed

// File: rtl/priority_request_arbiter_8.sv
// 8-way request arbiter: registered one-hot grant, hold-time limit, turnaround gap.
// Optional macro ROUND_ROBIN_EN selects rotating priority; default is fixed (7 highest).
module priority_request_arbiter_8 #(
  parameter int unsigned MAX_HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] request,
  output logic [7:0] grant,
  output logic [2:0] grant_index,
  output logic       grant_valid,
  output logic       timeout,
  output logic [1:0] fsm_state
);

  // Handshake: a requester raises request[i] and keeps it high while it wants the
  // resource; grant[i] stays high until request[i] is sampled low or the hold limit hits.

  localparam int unsigned HOLD_W = (MAX_HOLD_CYCLES == 0) ? 1 : $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((MAX_HOLD_CYCLES == 0) ? 0 : MAX_HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [3:0]        gap_cnt;
  logic [2:0]        search_start;
  logic [2:0]        cand;
  logic [2:0]        win_idx;
  logic              win_found;

`ifdef ROUND_ROBIN_EN
  logic [2:0] rr_ptr;
  // Search begins just below the previous winner so every requester gets a turn.
  assign search_start = rr_ptr - 3'd1;
`else
  assign search_start = 3'd7;
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = search_start - 3'(i);
      if (!win_found && request[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 8'd0;
      grant_index <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      gap_cnt     <= 4'd0;
`ifdef ROUND_ROBIN_EN
      rr_ptr      <= 3'd0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && win_found) begin
            grant       <= 8'b1 << win_idx;
            grant_index <= win_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
`ifdef ROUND_ROBIN_EN
            rr_ptr      <= win_idx;
`endif
          end
        end
        GRANT: begin
          // A dropped request wins over a simultaneous timeout: no pulse in that case.
          if (!request[grant_index]) begin
            grant       <= 8'd0;
            grant_valid <= 1'b0;
            gap_cnt     <= 4'd0;
            state       <= GAP;
          end else if (MAX_HOLD_CYCLES != 0 && hold_cnt == HOLD_LAST) begin
            grant       <= 8'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            gap_cnt     <= 4'd0;
            state       <= GAP;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= 8'd0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
